// File: rtl/apb_pkg.sv
// Shared types for the APB3 requester: FSM state encoding, default bus widths, response record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Completion record returned to the local requester. rdata is sized to the
    // default data width; a wider bus needs APB_DATA_W widened to match.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles that see PREADY low and flags the one that reaches TIMEOUT.
// Latency: expired is combinational on enable, so the abort lands on the same edge as the Nth count.
// Backpressure: none; TIMEOUT=0 removes the counter and holds expired low.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            // Wait-state counter: cleared on entry to ACCESS, counts each stalled cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // This stalled cycle is the TIMEOUT-th one when TIMEOUT-1 are already counted.
            assign expired = enable && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// APB3 requester: turns one valid/ready command into a single SETUP+ACCESS transfer and a response pulse.
// Latency: response pulse 2 edges after acceptance with no wait states, +1 per wait state; 3-cycle minimum period.
// Backpressure: cmd_ready only in IDLE (one outstanding transfer); rsp_valid cannot be stalled.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e state_q, state_d;
    apb_rsp_t   rsp_q, rsp_d;
    logic       rsp_vld_d;
    logic       timeout_hit;
    logic       accept;

    assign accept = (state_q == IDLE) && cmd_valid && cmd_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (state_q == SETUP),
        .enable  ((state_q == ACCESS) && !PREADY),
        .expired (timeout_hit)
    );

    // Next state and next response; a ready completer takes priority over the timeout.
    always_comb begin
        state_d   = state_q;
        rsp_vld_d = 1'b0;
        rsp_d     = rsp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d       = IDLE;
                    rsp_vld_d     = 1'b1;
                    rsp_d.rdata   = PWRITE ? '0 : APB_DATA_W'(PRDATA);
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    rsp_vld_d     = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and all outputs registered; bus controls derive from the next state so they change on the transition edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == IDLE);
            PSELx     <= (state_d != IDLE);
            PENABLE   <= (state_d == ACCESS);
            rsp_valid <= rsp_vld_d;
            rsp_q     <= rsp_d;
            // Address/direction/data are only loaded at acceptance, so they hold through and after the transfer.
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_write ? cmd_wdata : '0;
            end
        end
    end

    assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with TIMEOUT=4; inputs driven and outputs sampled on the falling edge.
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int vectors = 0;
    int errors  = 0;

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    // Response fields expected on a completion cycle.
    task automatic chk_rsp(input string tag, input logic [31:0] rd, input logic er, input logic to);
        chk({tag, ".rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, ".rsp_rdata"}, rsp_rdata, rd);
        chk({tag, ".rsp_err"}, rsp_err, er);
        chk({tag, ".rsp_timeout"}, rsp_timeout, to);
        chk({tag, ".psel_low"}, PSELx, 1'b0);
        chk({tag, ".penable_low"}, PENABLE, 1'b0);
        chk({tag, ".cmd_ready"}, cmd_ready, 1'b1);
    endtask

    logic [31:0] b2b_addr [3];

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.psel", PSELx, 1'b0);
        chk("rst.penable", PENABLE, 1'b0);
        chk("rst.cmd_ready", cmd_ready, 1'b0);
        chk("rst.rsp_valid", rsp_valid, 1'b0);
        chk("rst.paddr", PADDR, 32'h0);
        chk("rst.pwdata", PWDATA, 32'h0);
        chk("rst.pwrite", PWRITE, 1'b0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        PRESET = 1'b0;
        tick();
        chk("rel.cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write of 0xDEADBEEF to 0x10
        cmd(1'b1, 32'h10, 32'hDEADBEEF);
        PREADY = 1'b1;
        tick();                                     // after E0
        cmd_valid = 1'b0;
        chk("wr.setup.psel", PSELx, 1'b1);
        chk("wr.setup.penable", PENABLE, 1'b0);
        chk("wr.setup.cmd_ready", cmd_ready, 1'b0);
        chk("wr.setup.paddr", PADDR, 32'h10);
        chk("wr.setup.pwrite", PWRITE, 1'b1);
        chk("wr.setup.pwdata", PWDATA, 32'hDEADBEEF);
        tick();                                     // after E1
        chk("wr.access.psel", PSELx, 1'b1);
        chk("wr.access.penable", PENABLE, 1'b1);
        chk("wr.access.rsp_valid", rsp_valid, 1'b0);
        tick();                                     // after E2
        chk_rsp("wr", 32'h0, 1'b0, 1'b0);
        chk("wr.hold.paddr", PADDR, 32'h10);
        tick();
        chk("wr.pulse_end", rsp_valid, 1'b0);

        // One-wait read returning 0xDEADBEEF; PSLVERR during the wait must be ignored
        cmd(1'b0, 32'h10, 32'h55555555);
        PREADY = 1'b0;
        PRDATA = 32'hDEADBEEF;
        tick();
        cmd_valid = 1'b0;
        chk("rd.setup.pwrite", PWRITE, 1'b0);
        chk("rd.setup.pwdata", PWDATA, 32'h0);
        tick();
        chk("rd.access1.penable", PENABLE, 1'b1);
        PSLVERR = 1'b1;
        tick();
        chk("rd.access2.penable", PENABLE, 1'b1);
        chk("rd.access2.psel", PSELx, 1'b1);
        chk("rd.access2.rsp_valid", rsp_valid, 1'b0);
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        tick();
        chk_rsp("rd", 32'hDEADBEEF, 1'b0, 1'b0);
        PREADY = 1'b0;
        tick();

        // Completer error with PREADY
        cmd(1'b1, 32'h20, 32'h0000_1234);
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk_rsp("err", 32'h0, 1'b1, 1'b0);
        PSLVERR = 1'b0;
        PREADY  = 1'b0;
        tick();

        // Timeout: PREADY held low, abort at the edge ending the 4th stalled ACCESS cycle
        cmd(1'b0, 32'h30, 32'h0);
        PRDATA = 32'h12345678;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("to.wait%0d.penable", k), PENABLE, 1'b1);
            chk($sformatf("to.wait%0d.rsp_valid", k), rsp_valid, 1'b0);
        end
        tick();
        chk_rsp("to", 32'h0, 1'b1, 1'b1);
        tick();
        chk("to.pulse_end", rsp_valid, 1'b0);

        // PREADY arrives on the edge the timeout would fire: normal completion wins
        cmd(1'b0, 32'h34, 32'h0);
        PRDATA = 32'hCAFEF00D;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("tr.wait%0d.rsp_valid", k), rsp_valid, 1'b0);
        end
        PREADY = 1'b1;
        tick();
        chk_rsp("tr", 32'hCAFEF00D, 1'b0, 1'b0);
        tick();

        // Back-to-back writes with cmd_valid held high: acceptance every 3 cycles, PADDR stable per transfer
        b2b_addr[0] = 32'h40;
        b2b_addr[1] = 32'h44;
        b2b_addr[2] = 32'h48;
        cmd(1'b1, b2b_addr[0], 32'hA000_0040);
        for (int i = 0; i < 3; i++) begin
            tick();                                 // acceptance edge
            chk($sformatf("b2b%0d.setup.psel", i), PSELx, 1'b1);
            chk($sformatf("b2b%0d.setup.cmd_ready", i), cmd_ready, 1'b0);
            chk($sformatf("b2b%0d.setup.paddr", i), PADDR, b2b_addr[i]);
            chk($sformatf("b2b%0d.setup.pwdata", i), PWDATA, 32'hA000_0000 | b2b_addr[i]);
            if (i < 2) begin
                cmd_addr  = b2b_addr[i+1];
                cmd_wdata = 32'hA000_0000 | b2b_addr[i+1];
            end
            tick();
            chk($sformatf("b2b%0d.access.paddr", i), PADDR, b2b_addr[i]);
            chk($sformatf("b2b%0d.access.penable", i), PENABLE, 1'b1);
            tick();
            chk_rsp($sformatf("b2b%0d", i), 32'h0, 1'b0, 1'b0);
            chk($sformatf("b2b%0d.done.paddr", i), PADDR, b2b_addr[i]);
            if (i == 2) begin
                cmd_valid = 1'b0;
            end
        end
        tick();
        chk("b2b.idle.psel", PSELx, 1'b0);

        // Reset asserted during wait states
        cmd(1'b0, 32'h50, 32'h0);
        PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rs.wait.penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        tick();
        chk("rs.psel", PSELx, 1'b0);
        chk("rs.penable", PENABLE, 1'b0);
        chk("rs.rsp_valid", rsp_valid, 1'b0);
        chk("rs.cmd_ready", cmd_ready, 1'b0);
        PRESET = 1'b0;
        PREADY = 1'b1;
        tick();
        chk("rs.rel.cmd_ready", cmd_ready, 1'b1);
        chk("rs.rel.rsp_valid", rsp_valid, 1'b0);
        chk("rs.rel.psel", PSELx, 1'b0);
        tick();
        chk("rs.rel2.rsp_valid", rsp_valid, 1'b0);
        chk("rs.rel2.psel", PSELx, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
